// File: rtl/red_pitaya_fads_sort_ctrl.sv
// FADS sorting sequencer: segments ADC channel A into droplets, qualifies them and fires a timed ASG trigger.
// Optional statistics counters are built when FADS_SORT_STATS_EN is defined.
module red_pitaya_fads_sort_ctrl #(
  parameter int RSZ = 14,
  parameter int WW  = 16,
  parameter int DW  = 24,
  parameter int PW  = 16
) (
  input  logic          adc_clk_i,
  input  logic          adc_rstn_i,
  input  logic [13:0]   adc_a_i,
  input  logic          enable_i,
  input  logic [13:0]   low_thr_i,
  input  logic [13:0]   high_thr_i,
  input  logic [WW-1:0] min_width_i,
  input  logic [WW-1:0] max_width_i,
  input  logic [DW-1:0] sort_delay_i,
  input  logic [PW-1:0] pulse_len_i,
  input  logic          stats_clr_i,
  output logic          asg_trig_o,
  output logic          busy_o,
  output logic          drop_o,
  output logic [31:0]   drop_cnt_o,
  output logic [31:0]   sort_cnt_o
);

  localparam int unused_rsz = RSZ;

  typedef enum logic [2:0] {IDLE, DROP, DELAY, FIRE, REARM} state_t;

  state_t             state;
  logic signed [13:0] s;
  logic signed [13:0] peak;
  logic signed [13:0] low_thr;
  logic signed [13:0] high_thr;
  logic [WW-1:0]      width;
  logic [DW-1:0]      dcnt;
  logic [PW-1:0]      pcnt;
  logic [PW-1:0]      plen_eff;
  logic               above;
  logic               accept;

  assign low_thr  = $signed(low_thr_i);
  assign high_thr = $signed(high_thr_i);
  assign above    = s > low_thr;
  assign accept   = (peak >= high_thr) && (width >= min_width_i) && (width <= max_width_i);
  assign plen_eff = (pulse_len_i == '0) ? PW'(1) : pulse_len_i;

  // Delay and pulse length are captured at the accept decision so the pending sort is immune to later writes.
  always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
    if (!adc_rstn_i) begin
      state      <= IDLE;
      s          <= '0;
      peak       <= '0;
      width      <= '0;
      dcnt       <= '0;
      pcnt       <= '0;
      asg_trig_o <= 1'b0;
      busy_o     <= 1'b0;
      drop_o     <= 1'b0;
    end else begin
      s      <= $signed(adc_a_i);
      drop_o <= 1'b0;
      if (!enable_i) begin
        state      <= IDLE;
        asg_trig_o <= 1'b0;
        busy_o     <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (above) begin
              state <= DROP;
              width <= WW'(1);
              peak  <= s;
            end
          end
          DROP: begin
            if (above) begin
              if (width != '1) width <= width + WW'(1);
              if (s > peak) peak <= s;
            end else begin
              drop_o <= 1'b1;
              if (accept) begin
                dcnt   <= sort_delay_i;
                pcnt   <= plen_eff;
                busy_o <= 1'b1;
                if (sort_delay_i == '0) begin
                  state      <= FIRE;
                  asg_trig_o <= 1'b1;
                end else begin
                  state <= DELAY;
                end
              end else begin
                state <= IDLE;
              end
            end
          end
          DELAY: begin
            if (dcnt == DW'(1)) begin
              state      <= FIRE;
              asg_trig_o <= 1'b1;
            end else begin
              dcnt <= dcnt - DW'(1);
            end
          end
          FIRE: begin
            if (pcnt == PW'(1)) begin
              state      <= REARM;
              asg_trig_o <= 1'b0;
            end else begin
              pcnt <= pcnt - PW'(1);
            end
          end
          REARM: begin
            if (!above) begin
              state  <= IDLE;
              busy_o <= 1'b0;
            end
          end
          default: begin
            state      <= IDLE;
            asg_trig_o <= 1'b0;
            busy_o     <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef FADS_SORT_STATS_EN
  logic        drop_evt;
  logic        fire_evt;
  logic [31:0] drop_cnt;
  logic [31:0] sort_cnt;

  assign drop_evt = enable_i && (state == DROP) && !above;
  assign fire_evt = enable_i && (((state == DROP) && !above && accept && (sort_delay_i == '0)) ||
                                 ((state == DELAY) && (dcnt == DW'(1))));

  always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
    if (!adc_rstn_i) begin
      drop_cnt <= '0;
      sort_cnt <= '0;
    end else if (stats_clr_i) begin
      drop_cnt <= '0;
      sort_cnt <= '0;
    end else begin
      if (drop_evt) drop_cnt <= drop_cnt + 32'd1;
      if (fire_evt) sort_cnt <= sort_cnt + 32'd1;
    end
  end

  assign drop_cnt_o = drop_cnt;
  assign sort_cnt_o = sort_cnt;
`else
  logic unused_stats_clr;
  assign unused_stats_clr = stats_clr_i;
  assign drop_cnt_o = '0;
  assign sort_cnt_o = '0;
`endif

endmodule

// File: tb/tb_red_pitaya_fads_sort_ctrl.sv
// Directed bench for red_pitaya_fads_sort_ctrl: table of droplet vectors plus multi-cycle corner sequences.
module tb_red_pitaya_fads_sort_ctrl;

`ifdef FADS_SORT_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [13:0] adc_a;
  logic        enable;
  logic [13:0] low_thr;
  logic [13:0] high_thr;
  logic [15:0] min_width;
  logic [15:0] max_width;
  logic [23:0] sort_delay;
  logic [15:0] pulse_len;
  logic        stats_clr;
  logic        asg_trig;
  logic        busy;
  logic        drop;
  logic [31:0] drop_cnt;
  logic [31:0] sort_cnt;

  red_pitaya_fads_sort_ctrl dut (
    .adc_clk_i   (clk),
    .adc_rstn_i  (rst_n),
    .adc_a_i     (adc_a),
    .enable_i    (enable),
    .low_thr_i   (low_thr),
    .high_thr_i  (high_thr),
    .min_width_i (min_width),
    .max_width_i (max_width),
    .sort_delay_i(sort_delay),
    .pulse_len_i (pulse_len),
    .stats_clr_i (stats_clr),
    .asg_trig_o  (asg_trig),
    .busy_o      (busy),
    .drop_o      (drop),
    .drop_cnt_o  (drop_cnt),
    .sort_cnt_o  (sort_cnt)
  );

  always #5 clk = ~clk;

  // Cycle counter and negedge monitor; tests read cumulative values and work on deltas.
  int cyc = 0;
  int drops_seen = 0;
  int trig_hi = 0;
  int rise_cyc = -1;
  logic trig_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (drop) drops_seen <= drops_seen + 1;
    if (asg_trig) trig_hi <= trig_hi + 1;
    if (asg_trig && !trig_prev) rise_cyc <= cyc;
    trig_prev <= asg_trig;
  end

  int n_cmp = 0;
  int n_bad = 0;
  int exp_drop = 0;
  int exp_sort = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input int v);
    @(negedge clk);
    adc_a = 14'(v);
  endtask

  task automatic check_counters(input string tag);
    @(negedge clk);
    check({tag, ".drop_cnt"}, drop_cnt, STATS ? exp_drop : 0);
    check({tag, ".sort_cnt"}, sort_cnt, STATS ? exp_sort : 0);
  endtask

  // One droplet of width w with a single sample at pk (others 100); returns cycle of the first low sample.
  task automatic droplet(input int w, input int pk, output int low_cyc);
    repeat (3) drive(0);
    for (int i = 0; i < w; i++) drive((i == w / 2) ? pk : 100);
    drive(0);
    low_cyc = cyc;
  endtask

  typedef struct {
    int w;
    int pk;
    int d;
    int p;
    bit srt;
  } vec_t;

  vec_t tbl[9];

  initial begin
    int d0, t0, lc, waited, ep;

    tbl[0] = '{w: 5,  pk: 300, d: 100, p: 20, srt: 1'b1};
    tbl[1] = '{w: 5,  pk: 150, d: 100, p: 20, srt: 1'b0};
    tbl[2] = '{w: 2,  pk: 300, d: 10,  p: 5,  srt: 1'b0};
    tbl[3] = '{w: 11, pk: 300, d: 10,  p: 5,  srt: 1'b0};
    tbl[4] = '{w: 3,  pk: 300, d: 10,  p: 5,  srt: 1'b1};
    tbl[5] = '{w: 10, pk: 300, d: 10,  p: 5,  srt: 1'b1};
    tbl[6] = '{w: 5,  pk: 300, d: 0,   p: 0,  srt: 1'b1};
    tbl[7] = '{w: 4,  pk: 200, d: 7,   p: 3,  srt: 1'b1};
    tbl[8] = '{w: 1,  pk: 300, d: 7,   p: 3,  srt: 1'b0};

    rst_n = 1'b0; adc_a = '0; enable = 1'b1; stats_clr = 1'b0;
    low_thr = 14'd15; high_thr = 14'd200; min_width = 16'd3; max_width = 16'd10;
    sort_delay = 24'd100; pulse_len = 16'd20;
    repeat (3) @(negedge clk);
    check("reset.asg_trig", asg_trig, 0);
    check("reset.busy", busy, 0);
    check("reset.drop", drop, 0);
    check("reset.drop_cnt", drop_cnt, 0);
    check("reset.sort_cnt", sort_cnt, 0);
    rst_n = 1'b1;

    foreach (tbl[k]) begin
      sort_delay = 24'(tbl[k].d);
      pulse_len  = 16'(tbl[k].p);
      d0 = drops_seen; t0 = trig_hi;
      droplet(tbl[k].w, tbl[k].pk, lc);
      repeat (tbl[k].d + tbl[k].p + 10) drive(0);
      ep = tbl[k].srt ? ((tbl[k].p == 0) ? 1 : tbl[k].p) : 0;
      check($sformatf("vec%0d.drops", k), drops_seen - d0, 1);
      check($sformatf("vec%0d.trig_cycles", k), trig_hi - t0, ep);
      if (tbl[k].srt) check($sformatf("vec%0d.rise", k), rise_cyc - lc, 2 + tbl[k].d);
      check($sformatf("vec%0d.busy_end", k), busy, 0);
      exp_drop++;
      if (tbl[k].srt) exp_sort++;
      check_counters($sformatf("vec%0d", k));
      $display("vec %0d: width=%0d peak=%0d D=%0d P=%0d sort=%0d trig_cycles=%0d", k,
               tbl[k].w, tbl[k].pk, tbl[k].d, tbl[k].p, tbl[k].srt, trig_hi - t0);
    end

    // Second droplet during DELAY, still high when FIRE ends; config changes after accept must not matter.
    sort_delay = 24'd20; pulse_len = 16'd5;
    d0 = drops_seen; t0 = trig_hi;
    droplet(5, 300, lc);
    repeat (4) drive(0);
    sort_delay = 24'd3; pulse_len = 16'd50;
    repeat (35) drive(300);
    check("rearm.busy_held", busy, 1);
    check("rearm.rise", rise_cyc - lc, 22);
    check("rearm.trig_cycles", trig_hi - t0, 5);
    repeat (5) drive(0);
    check("rearm.busy_released", busy, 0);
    check("rearm.drops", drops_seen - d0, 1);
    exp_drop++; exp_sort++;
    check_counters("rearm");
    $display("seq rearm: drops=%0d trig_cycles=%0d", drops_seen - d0, trig_hi - t0);

    // enable low during DELAY discards the pending sort.
    sort_delay = 24'd50; pulse_len = 16'd5;
    d0 = drops_seen; t0 = trig_hi;
    droplet(5, 300, lc);
    repeat (5) drive(0);
    enable = 1'b0;
    repeat (2) drive(0);
    enable = 1'b1;
    repeat (60) drive(0);
    check("enable.trig_cycles", trig_hi - t0, 0);
    check("enable.busy", busy, 0);
    check("enable.drops", drops_seen - d0, 1);
    exp_drop++;
    check_counters("enable");
    $display("seq enable: drops=%0d trig_cycles=%0d", drops_seen - d0, trig_hi - t0);

`ifdef FADS_SORT_STATS_EN
    @(negedge clk);
    stats_clr = 1'b1;
    @(negedge clk);
    stats_clr = 1'b0;
    exp_drop = 0; exp_sort = 0;
    check_counters("clear");
    $display("seq clear: drop_cnt=%0d sort_cnt=%0d", drop_cnt, sort_cnt);
`endif

    // Asynchronous reset in the middle of FIRE.
    sort_delay = 24'd5; pulse_len = 16'd20;
    droplet(5, 300, lc);
    waited = 0;
    while (!asg_trig && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    check("areset.fire_reached", asg_trig, 1);
    #2 rst_n = 1'b0;
    #1;
    check("areset.asg_trig", asg_trig, 0);
    check("areset.busy", busy, 0);
    check("areset.drop_cnt", drop_cnt, 0);
    check("areset.sort_cnt", sort_cnt, 0);
    exp_drop = 0; exp_sort = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    $display("seq areset: asg_trig=%0d busy=%0d after reset", asg_trig, busy);

    // Normal operation resumes from IDLE after reset.
    sort_delay = 24'd4; pulse_len = 16'd2;
    t0 = trig_hi;
    droplet(4, 250, lc);
    repeat (12) drive(0);
    check("post_reset.rise", rise_cyc - lc, 6);
    check("post_reset.trig_cycles", trig_hi - t0, 2);
    exp_drop++; exp_sort++;
    check_counters("post_reset");
    $display("seq post_reset: trig_cycles=%0d", trig_hi - t0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
